// File: rtl/sprite_rom.sv
// Registered sprite colour lookup (apple or basket) for the catch-the-apple display.
// Optional macro APPLE_HIGHLIGHT_EN adds a white highlight disc to the apple.
module sprite_rom #(
   parameter int          SPRITE   = 0,
   parameter logic [11:0] BG_COLOR = 12'h251
) (
   input  logic        clk,
   input  logic        start,
   input  logic [9:0]  row,
   input  logic [9:0]  col,
   output logic [11:0] color_data
);

   localparam bit         IS_BASKET = (SPRITE == 1);
   localparam logic [9:0] WIDTH     = IS_BASKET ? 10'd65 : 10'd33;
   localparam logic [9:0] HEIGHT    = 10'd33;

   localparam logic [11:0] APPLE_STEM   = 12'h840;
   localparam logic [11:0] APPLE_LEAF   = 12'h0A0;
   localparam logic [11:0] APPLE_BODY   = 12'hF00;
   localparam logic [11:0] BASKET_RIM   = 12'h520;
   localparam logic [11:0] BASKET_DARK  = 12'h840;
   localparam logic [11:0] BASKET_LIGHT = 12'hC80;

   logic               in_range;
   logic signed [11:0] row_s;
   logic signed [11:0] col_s;
   logic signed [11:0] body_dc;
   logic signed [11:0] body_dr;
   logic signed [23:0] body_d2;
   logic               is_stem;
   logic               is_leaf;
   logic               is_apple_body;
   logic [11:0]        apple_color;
   logic [9:0]         basket_k;
   logic               is_rim;
   logic               is_basket_body;
   logic [11:0]        basket_color;
   logic [11:0]        next_color;

   // Full 10-bit compare: wrapped negative offsets land far outside the box.
   assign in_range = (row < HEIGHT) && (col < WIDTH);

   assign row_s = signed'({2'b00, row});
   assign col_s = signed'({2'b00, col});

   assign body_dc = col_s - 12'sd16;
   assign body_dr = row_s - 12'sd18;
   assign body_d2 = body_dc * body_dc + body_dr * body_dr;

   assign is_stem       = ((col == 10'd16) || (col == 10'd17)) && (row <= 10'd4);
   assign is_leaf       = ((row == 10'd3) || (row == 10'd4)) &&
                          (col >= 10'd18) && (col <= 10'd22);
   assign is_apple_body = (body_d2 <= 24'sd196);

`ifdef APPLE_HIGHLIGHT_EN
   logic signed [11:0] hl_dc;
   logic signed [11:0] hl_dr;
   logic signed [23:0] hl_d2;
   logic               is_highlight;

   assign hl_dc        = col_s - 12'sd11;
   assign hl_dr        = row_s - 12'sd13;
   assign hl_d2        = hl_dc * hl_dc + hl_dr * hl_dr;
   assign is_highlight = (hl_d2 <= 24'sd4);
`else
   logic is_highlight;
   assign is_highlight = 1'b0;
`endif

   always_comb begin
      apple_color = BG_COLOR;
      if (is_stem)
         apple_color = APPLE_STEM;
      else if (is_leaf)
         apple_color = APPLE_LEAF;
      else if (is_highlight)
         apple_color = 12'hFFF;
      else if (is_apple_body)
         apple_color = APPLE_BODY;
   end

   // Basket narrows by one column per side every four rows below the rim.
   assign basket_k       = (row - 10'd4) >> 2;
   assign is_rim         = (row <= 10'd3);
   assign is_basket_body = (row >= 10'd4) && (row <= 10'd32) &&
                           (col >= basket_k) && (col <= (10'd64 - basket_k));

   always_comb begin
      basket_color = BG_COLOR;
      if (is_rim)
         basket_color = BASKET_RIM;
      else if (is_basket_body)
         basket_color = (row[2] ^ col[2]) ? BASKET_LIGHT : BASKET_DARK;
   end

   always_comb begin
      next_color = BG_COLOR;
      if (in_range)
         next_color = IS_BASKET ? basket_color : apple_color;
   end

   always_ff @(posedge clk or posedge start) begin
      if (start)
         color_data <= 12'h000;
      else
         color_data <= next_color;
   end

endmodule

// File: tb/tb_sprite_rom.sv
// Directed bench for sprite_rom: one apple and one basket instance side by side.
module tb_sprite_rom;

   logic        clk;
   logic        start;
   logic [9:0]  a_row;
   logic [9:0]  a_col;
   logic [9:0]  b_row;
   logic [9:0]  b_col;
   logic [11:0] a_color;
   logic [11:0] b_color;

   int checks = 0;
   int errors = 0;

   logic [11:0] exp_q[$];

`ifdef APPLE_HIGHLIGHT_EN
   localparam bit HL = 1'b1;
`else
   localparam bit HL = 1'b0;
`endif

   sprite_rom #(.SPRITE(0), .BG_COLOR(12'h251)) u_apple (
      .clk        (clk),
      .start      (start),
      .row        (a_row),
      .col        (a_col),
      .color_data (a_color)
   );

   sprite_rom #(.SPRITE(1), .BG_COLOR(12'h251)) u_basket (
      .clk        (clk),
      .start      (start),
      .row        (b_row),
      .col        (b_col),
      .color_data (b_color)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] apple_model(input int r, input int c);
      if (r < 0 || r > 32 || c < 0 || c > 32) return 12'h251;
      if ((c == 16 || c == 17) && r <= 4) return 12'h840;
      if ((r == 3 || r == 4) && c >= 18 && c <= 22) return 12'h0A0;
      if (HL && ((c - 11) * (c - 11) + (r - 13) * (r - 13) <= 4)) return 12'hFFF;
      if ((c - 16) * (c - 16) + (r - 18) * (r - 18) <= 196) return 12'hF00;
      return 12'h251;
   endfunction

   function automatic logic [11:0] basket_model(input int r, input int c);
      int k;
      if (r < 0 || r > 32 || c < 0 || c > 64) return 12'h251;
      if (r <= 3) return 12'h520;
      k = (r - 4) / 4;
      if (c < k || c > 64 - k) return 12'h251;
      if (((r / 4) + (c / 4)) % 2 == 0) return 12'h840;
      return 12'hC80;
   endfunction

   task automatic test_reset();
      start = 1'b0;
      a_row = 10'd18; a_col = 10'd16;
      b_row = 10'd0;  b_col = 10'd0;
      #2 start = 1'b1;
      #1;
      checks++;
      if (a_color !== 12'h000) begin
         errors++;
         $display("FAIL reset_apple_async got %h want %h", a_color, 12'h000);
      end
      checks++;
      if (b_color !== 12'h000) begin
         errors++;
         $display("FAIL reset_basket_async got %h want %h", b_color, 12'h000);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (a_color !== 12'h000) begin
         errors++;
         $display("FAIL reset_held got %h want %h", a_color, 12'h000);
      end
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (a_color !== 12'hF00) begin
         errors++;
         $display("FAIL reset_release_apple got %h want %h", a_color, 12'hF00);
      end
      checks++;
      if (b_color !== 12'h520) begin
         errors++;
         $display("FAIL reset_release_basket got %h want %h", b_color, 12'h520);
      end
   endtask

   task automatic test_apple_map();
      logic [9:0]  rr[4] = '{10'd0, 10'd3, 10'd0, 10'd32};
      logic [9:0]  cc[4] = '{10'd16, 10'd20, 10'd0, 10'd16};
      logic [11:0] ee[4] = '{12'h840, 12'h0A0, 12'h251, 12'hF00};
      for (int i = 0; i < 4; i++) begin
         a_row = rr[i]; a_col = cc[i];
         @(posedge clk);
         #1;
         checks++;
         if (a_color !== ee[i]) begin
            errors++;
            $display("FAIL apple_map[%0d] r=%0d c=%0d got %h want %h",
                     i, rr[i], cc[i], a_color, ee[i]);
         end
      end
   endtask

   task automatic test_apple_highlight();
      logic [11:0] want;
      want = HL ? 12'hFFF : 12'hF00;
      a_row = 10'd13; a_col = 10'd11;
      @(posedge clk);
      #1;
      checks++;
      if (a_color !== want) begin
         errors++;
         $display("FAIL apple_highlight got %h want %h", a_color, want);
      end
   endtask

   task automatic test_basket_map();
      logic [9:0]  rr[5] = '{10'd0, 10'd4, 10'd8, 10'd32, 10'd32};
      logic [9:0]  cc[5] = '{10'd64, 10'd0, 10'd8, 10'd0, 10'd7};
      logic [11:0] ee[5] = '{12'h520, 12'hC80, 12'h840, 12'h251, 12'hC80};
      for (int i = 0; i < 5; i++) begin
         b_row = rr[i]; b_col = cc[i];
         @(posedge clk);
         #1;
         checks++;
         if (b_color !== ee[i]) begin
            errors++;
            $display("FAIL basket_map[%0d] r=%0d c=%0d got %h want %h",
                     i, rr[i], cc[i], b_color, ee[i]);
         end
      end
   endtask

   task automatic test_out_of_range();
      logic [9:0] ar[3] = '{10'd0, 10'd33, 10'h3FF};
      logic [9:0] ac[3] = '{10'h3FF, 10'd16, 10'd16};
      logic [9:0] br[3] = '{10'd0, 10'd10, 10'h3FF};
      logic [9:0] bc[3] = '{10'h3FF, 10'd65, 10'd10};
      for (int i = 0; i < 3; i++) begin
         a_row = ar[i]; a_col = ac[i];
         b_row = br[i]; b_col = bc[i];
         @(posedge clk);
         #1;
         checks++;
         if (a_color !== 12'h251) begin
            errors++;
            $display("FAIL oor_apple[%0d] got %h want %h", i, a_color, 12'h251);
         end
         checks++;
         if (b_color !== 12'h251) begin
            errors++;
            $display("FAIL oor_basket[%0d] got %h want %h", i, b_color, 12'h251);
         end
      end
   endtask

   task automatic test_mid_cycle();
      a_row = 10'd0; a_col = 10'd16;
      @(posedge clk);
      #1;
      a_row = 10'd0; a_col = 10'd0;
      #3;
      checks++;
      if (a_color !== 12'h840) begin
         errors++;
         $display("FAIL mid_cycle_hold got %h want %h", a_color, 12'h840);
      end
      @(posedge clk);
      #1;
      checks++;
      if (a_color !== 12'h251) begin
         errors++;
         $display("FAIL mid_cycle_next got %h want %h", a_color, 12'h251);
      end
   endtask

   task automatic test_back_to_back();
      logic [11:0] want;
      exp_q.delete();
      for (int r = 0; r < 33; r++) begin
         for (int c = 0; c < 65; c++) begin
            b_row = 10'(r); b_col = 10'(c);
            exp_q.push_back(basket_model(r, c));
            @(posedge clk);
            #1;
            want = exp_q.pop_front();
            checks++;
            if (b_color !== want) begin
               errors++;
               $display("FAIL b2b_basket r=%0d c=%0d got %h want %h", r, c, b_color, want);
            end
         end
      end
      for (int r = 0; r < 33; r++) begin
         for (int c = 0; c < 33; c++) begin
            a_row = 10'(r); a_col = 10'(c);
            exp_q.push_back(apple_model(r, c));
            @(posedge clk);
            #1;
            want = exp_q.pop_front();
            checks++;
            if (a_color !== want) begin
               errors++;
               $display("FAIL b2b_apple r=%0d c=%0d got %h want %h", r, c, a_color, want);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_apple_map();
      test_apple_highlight();
      test_basket_map();
      test_out_of_range();
      test_mid_cycle();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
